// File: rtl/y86_mem_pkg.sv
// ----------------------------------------------------------------------------
// y86_mem_pkg
// Shared definitions for the Y86-64 memory stage: icode constants that touch
// data memory, the handshake FSM state type, and a decoder that turns an
// icode into the memory operation it performs.
// ----------------------------------------------------------------------------
package y86_mem_pkg;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // rd/wr select the access type; addr_a picks valA instead of valE as the
    // address (stack pops), data_p picks valP instead of valA as write data.
    typedef struct packed {
        logic rd;
        logic wr;
        logic addr_a;
        logic data_p;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [3:0] icode);
        mem_op_t op;
        op = '0;
        case (icode)
            IRMMOVQ, IPUSHQ: op.wr = 1'b1;
            IMRMOVQ:         op.rd = 1'b1;
            ICALL: begin
                op.wr     = 1'b1;
                op.data_p = 1'b1;
            end
            IRET, IPOPQ: begin
                op.rd     = 1'b1;
                op.addr_a = 1'b1;
            end
            default: op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/data_ram.sv
// ----------------------------------------------------------------------------
// data_ram
// Byte-addressed data memory holding 64-bit little-endian words at any byte
// offset. One synchronous 8-byte write port, one asynchronous 8-byte read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   addr  : byte address of the least-significant byte
//   wdata : write data
//   rdata : combinational read data at addr
// The caller guarantees addr <= MEM_BYTES-8, so addr+7 never leaves the array.
// ----------------------------------------------------------------------------
module data_ram #(
    parameter int MEM_BYTES = 256,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[addr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[addr + AW'(i)];
        end
    end

endmodule

// File: rtl/mem_stage_hs.sv
// ----------------------------------------------------------------------------
// mem_stage_hs
// Y86-64 memory stage with valid/ready handshakes on both sides and a fixed
// number of wait cycles before each data memory access.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake; ready only while IDLE
//   icode, valE, valA,  : instruction code, execute result, register A,
//   valP                  next PC
//   out_valid/out_ready : downstream handshake; result held while in RESP
//   valM                : read data (0 for writes, non-memory ops, errors)
//   mem_read, mem_write : high during the single access cycle
//   dmem_error          : address was out of range
//   err_count           : saturating count of delivered error responses
// ----------------------------------------------------------------------------
module mem_stage_hs
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int WAIT      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valM,
    output logic        mem_read,
    output logic        mem_write,
    output logic        dmem_error,
    output logic [7:0]  err_count
);

    localparam int          AW       = $clog2(MEM_BYTES);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [63:0]   wdata_q;
    logic          rd_q;
    logic          wr_q;

    mem_op_t       op;
    logic [63:0]   addr_sel;
    logic [63:0]   wdata_sel;
    logic          addr_ok;
    logic [63:0]   rdata;

    // Operand selection and range check on the live inputs; the compare is a
    // full 64-bit unsigned one so huge addresses cannot wrap into range.
    always_comb begin
        op        = decode_op(icode);
        addr_sel  = op.addr_a ? valA : valE;
        wdata_sel = op.data_p ? valP : valA;
        addr_ok   = (addr_sel <= ADDR_MAX);
    end

    // Strobes decode straight from the state register so reset kills them
    // immediately, which also stops an in-flight write from committing.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign mem_read  = (state == BUSY) && (cnt == 4'd0) && rd_q;
    assign mem_write = (state == BUSY) && (cnt == 4'd0) && wr_q;

    data_ram #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (mem_write),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            valM       <= '0;
            dmem_error <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if ((op.rd || op.wr) && addr_ok) begin
                            addr_q  <= addr_sel[AW-1:0];
                            wdata_q <= wdata_sel;
                            rd_q    <= op.rd;
                            wr_q    <= op.wr;
                            cnt     <= WAIT_CNT;
                            state   <= BUSY;
                        end else begin
                            // Bad address or no memory op: answer at once.
                            valM       <= '0;
                            dmem_error <= op.rd || op.wr;
                            state      <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        valM       <= rd_q ? rdata : 64'd0;
                        dmem_error <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        if (dmem_error && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_hs
// Directed, table-driven bench for mem_stage_hs with WAIT=2, MEM_BYTES=256.
// ----------------------------------------------------------------------------
module tb_mem_stage_hs;
    import y86_mem_pkg::*;

    localparam int MEM_BYTES = 256;
    localparam int WAIT      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valE = '0;
    logic [63:0] valA = '0;
    logic [63:0] valP = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] valM;
    logic        mem_read;
    logic        mem_write;
    logic        dmem_error;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    mem_stage_hs #(
        .MEM_BYTES (MEM_BYTES),
        .WAIT      (WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .icode      (icode),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .valM       (valM),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .dmem_error (dmem_error),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic [63:0] expValM;
        logic        expErr;
        int          expLat;
        int          expRd;
        int          expWr;
        logic [7:0]  expErrCnt;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic addVec(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                          input logic [63:0] p, input logic [63:0] m, input logic er,
                          input int rd, input int wr, input logic [7:0] ec);
        vec_t v;
        v.icode = ic; v.valE = e; v.valA = a; v.valP = p;
        v.expValM = m; v.expErr = er;
        v.expLat = (rd + wr != 0) ? WAIT + 1 : 0;
        v.expRd = rd; v.expWr = wr; v.expErrCnt = ec;
        vecs.push_back(v);
    endtask

    // Presents one instruction, waits for the accept edge, then counts rising
    // edges until out_valid (lat) and records strobe activity on the way.
    task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] e,
                                 input logic [63:0] a, input logic [63:0] p,
                                 output int lat, output int rdCnt, output int wrCnt,
                                 output int accLat);
        @(negedge clk);
        icode = ic; valE = e; valA = a; valP = p; in_valid = 1'b1;
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; rdCnt = 0; wrCnt = 0; accLat = -1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (mem_read) rdCnt++;
            if (mem_write) begin
                wrCnt++;
                accLat = lat;
            end
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", lat);
        end
    endtask

    task automatic finishResp();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, rdc, wrc, acc;
        string n;

        // Reset state, sampled while rst_n is still low.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready",   64'(in_ready),   64'd1);
        checkOutput("rst_out_valid",  64'(out_valid),  64'd0);
        checkOutput("rst_valM",       valM,            64'd0);
        checkOutput("rst_dmem_error", 64'(dmem_error), 64'd0);
        checkOutput("rst_err_count",  64'(err_count),  64'd0);
        checkOutput("rst_mem_read",   64'(mem_read),   64'd0);
        checkOutput("rst_mem_write",  64'(mem_write),  64'd0);
        rst_n = 1'b1;
        #1 checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        //     icode    valE                    valA                    valP    expValM                 err  rd wr ec
        addVec(IRMMOVQ, 64'd5,                  64'd10,                 64'd0,  64'd0,                  0,   0, 1, 8'd0);
        addVec(IMRMOVQ, 64'd5,                  64'd0,                  64'd0,  64'd10,                 0,   1, 0, 8'd0);
        addVec(IMRMOVQ, 64'd280,                64'd0,                  64'd0,  64'd0,                  1,   0, 0, 8'd1);
        addVec(ICALL,   64'd1,                  64'd99,                 64'd13, 64'd0,                  0,   0, 1, 8'd1);
        addVec(IRET,    64'd0,                  64'd1,                  64'd0,  64'd13,                 0,   1, 0, 8'd1);
        addVec(IMRMOVQ, 64'd5,                  64'd0,                  64'd0,  64'd0,                  0,   1, 0, 8'd1);
        addVec(IPOPQ,   64'd0,                  64'd249,                64'd0,  64'd0,                  1,   0, 0, 8'd2);
        addVec(IPUSHQ,  64'd248,                64'hDEADBEEF_01234567,  64'd0,  64'd0,                  0,   0, 1, 8'd2);
        addVec(IPOPQ,   64'd0,                  64'd248,                64'd0,  64'hDEADBEEF_01234567,  0,   1, 0, 8'd2);
        addVec(IMRMOVQ, 64'hFFFFFFFF_FFFFFFF8,  64'd0,                  64'd0,  64'd0,                  1,   0, 0, 8'd3);
        addVec(4'h3,    64'd5,                  64'd5,                  64'd0,  64'd0,                  0,   0, 0, 8'd3);
        addVec(IRMMOVQ, 64'd100,                64'h11223344_55667788,  64'd0,  64'd0,                  0,   0, 1, 8'd3);
        addVec(IRMMOVQ, 64'd103,                64'hAABBCCDD_EEFF0011,  64'd0,  64'd0,                  0,   0, 1, 8'd3);
        addVec(IMRMOVQ, 64'd100,                64'd0,                  64'd0,  64'hDDEEFF00_11667788,  0,   1, 0, 8'd3);
        addVec(IRMMOVQ, 64'd16,                 64'h01234567_89ABCDEF,  64'd0,  64'd0,                  0,   0, 1, 8'd3);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].icode, vecs[i].valE, vecs[i].valA, vecs[i].valP,
                          lat, rdc, wrc, acc);
            n = $sformatf("v%0d", i);
            checkOutput({n, "_latency"},    64'(lat),        64'(vecs[i].expLat));
            checkOutput({n, "_valM"},       valM,            vecs[i].expValM);
            checkOutput({n, "_dmem_error"}, 64'(dmem_error), 64'(vecs[i].expErr));
            checkOutput({n, "_rd_pulses"},  64'(rdc),        64'(vecs[i].expRd));
            checkOutput({n, "_wr_pulses"},  64'(wrc),        64'(vecs[i].expWr));
            if (vecs[i].expWr != 0)
                checkOutput({n, "_wr_cycle"}, 64'(acc), 64'(WAIT));
            finishResp();
            checkOutput({n, "_err_count"},  64'(err_count),  64'(vecs[i].expErrCnt));
            checkOutput({n, "_back_idle"},  64'(in_ready),   64'd1);
        end

        // Stall in RESP with a competing request held on the input.
        applyStimulus(IMRMOVQ, 64'd100, 64'd0, 64'd0, lat, rdc, wrc, acc);
        icode = IRMMOVQ; valE = 64'd100; valA = 64'hFF; in_valid = 1'b1;
        wrc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_write) wrc++;
            checkOutput($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'd1);
            checkOutput($sformatf("stall%0d_valM", k), valM, 64'hDDEEFF00_11667788);
            checkOutput($sformatf("stall%0d_dmem_error", k), 64'(dmem_error), 64'd0);
            checkOutput($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("release_in_ready",  64'(in_ready),  64'd1);
        checkOutput("release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("stall_no_write",    64'(wrc),       64'd0);
        applyStimulus(IMRMOVQ, 64'd100, 64'd0, 64'd0, lat, rdc, wrc, acc);
        checkOutput("after_stall_data", valM, 64'hDDEEFF00_11667788);
        finishResp();

        // err_count saturation: from 3 up to 255, then two more errors.
        for (int k = 0; k < 251; k++) begin
            applyStimulus(IMRMOVQ, 64'd280, 64'd0, 64'd0, lat, rdc, wrc, acc);
            finishResp();
        end
        checkOutput("err_count_254", 64'(err_count), 64'd254);
        applyStimulus(IMRMOVQ, 64'd280, 64'd0, 64'd0, lat, rdc, wrc, acc);
        finishResp();
        checkOutput("err_count_255", 64'(err_count), 64'd255);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(IPOPQ, 64'd0, 64'd300, 64'd0, lat, rdc, wrc, acc);
            finishResp();
        end
        checkOutput("err_count_sat", 64'(err_count), 64'd255);

        // Reset arrives during the access cycle of a pushq to address 16.
        @(negedge clk);
        icode = IPUSHQ; valE = 64'd16; valA = 64'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_in_access", 64'(mem_write), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_mem_write",  64'(mem_write),  64'd0);
        checkOutput("abort_mem_read",   64'(mem_read),   64'd0);
        checkOutput("abort_out_valid",  64'(out_valid),  64'd0);
        checkOutput("abort_valM",       valM,            64'd0);
        checkOutput("abort_dmem_error", 64'(dmem_error), 64'd0);
        checkOutput("abort_err_count",  64'(err_count),  64'd0);
        checkOutput("abort_in_ready",   64'(in_ready),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("abort_first_cycle_ready", 64'(in_ready), 64'd1);
        applyStimulus(IMRMOVQ, 64'd16, 64'd0, 64'd0, lat, rdc, wrc, acc);
        checkOutput("abort_mem_kept", valM, 64'h01234567_89ABCDEF);
        checkOutput("abort_read_lat", 64'(lat), 64'(WAIT + 1));
        finishResp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
